// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for one shared single-port memory.
// Requester A (fetch) and B (load/store) take turns; each access lasts LATENCY cycles.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic ReqA,
    input  logic WeA,
    input  logic ReqB,
    input  logic WeB,
    output logic Sel,
    output logic MemEn,
    output logic MemWe,
    output logic GntA,
    output logic GntB,
    output logic DoneA,
    output logic DoneB,
    output logic Busy
);

    typedef enum logic [1:0] {StIdle, StBusyA, StBusyB} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_b_q, last_b_d;
    logic             sel_q, sel_d;
    logic             last_cycle;

    assign last_cycle = (cnt_q == LastCnt);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        sel_d    = sel_q;
        GntA     = 1'b0;
        GntB     = 1'b0;
        DoneA    = 1'b0;
        DoneB    = 1'b0;
        MemWe    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // last_b_q set means B won last time, so A wins a tie
                if (ReqA && (!ReqB || last_b_q)) begin
                    state_d  = StBusyA;
                    cnt_d    = '0;
                    sel_d    = 1'b0;
                    last_b_d = 1'b0;
                end else if (ReqB) begin
                    state_d  = StBusyB;
                    cnt_d    = '0;
                    sel_d    = 1'b1;
                    last_b_d = 1'b1;
                end
            end
            StBusyA: begin
                GntA  = 1'b1;
                MemWe = WeA;
                DoneA = last_cycle;
                cnt_d = cnt_q + 1'b1;
                if (last_cycle) state_d = StIdle;
            end
            StBusyB: begin
                GntB  = 1'b1;
                MemWe = WeB;
                DoneB = last_cycle;
                cnt_d = cnt_q + 1'b1;
                if (last_cycle) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign Busy  = (state_q != StIdle);
    assign MemEn = Busy;
    assign Sel   = sel_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            sel_q    <= sel_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// against a transaction-level model (owner + cycles remaining).
module tb_mem_port_arbiter;

    localparam int unsigned Lat = 2;

    logic Clk = 1'b0;
    logic Reset_n, ReqA, WeA, ReqB, WeB;
    logic Sel, MemEn, MemWe, GntA, GntB, DoneA, DoneB, Busy;

    logic Reset1_n, ReqA1, WeA1, ReqB1, WeB1;
    logic Sel1, MemEn1, MemWe1, GntA1, GntB1, DoneA1, DoneB1, Busy1;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.LATENCY(Lat), .CNT_W(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ReqA(ReqA), .WeA(WeA), .ReqB(ReqB), .WeB(WeB),
        .Sel(Sel), .MemEn(MemEn), .MemWe(MemWe), .GntA(GntA), .GntB(GntB),
        .DoneA(DoneA), .DoneB(DoneB), .Busy(Busy)
    );

    mem_port_arbiter #(.LATENCY(1), .CNT_W(4)) dut1 (
        .Clk(Clk), .Reset_n(Reset1_n), .ReqA(ReqA1), .WeA(WeA1), .ReqB(ReqB1), .WeB(WeB1),
        .Sel(Sel1), .MemEn(MemEn1), .MemWe(MemWe1), .GntA(GntA1), .GntB(GntB1),
        .DoneA(DoneA1), .DoneB(DoneB1), .Busy(Busy1)
    );

    // {Sel, MemEn, MemWe, GntA, GntB, DoneA, DoneB, Busy}
    logic [7:0] obs, obs1;
    assign obs  = {Sel, MemEn, MemWe, GntA, GntB, DoneA, DoneB, Busy};
    assign obs1 = {Sel1, MemEn1, MemWe1, GntA1, GntB1, DoneA1, DoneB1, Busy1};

    // Reference model: who owns the port, how many cycles are left, who won last.
    int   m_owner;  // 0 none, 1 A, 2 B
    int   m_left;
    logic m_last_b;
    logic m_sel;

    function automatic void model_reset();
        m_owner  = 0;
        m_left   = 0;
        m_last_b = 1'b1;
        m_sel    = 1'b0;
    endfunction

    function automatic void model_edge(input logic ra, input logic rb);
        if (m_owner != 0) begin
            m_left--;
            if (m_left == 0) m_owner = 0;
        end else if (ra || rb) begin
            m_owner  = (ra && (!rb || m_last_b)) ? 1 : 2;
            m_left   = Lat;
            m_sel    = (m_owner == 2);
            m_last_b = m_sel;
        end
    endfunction

    function automatic logic [7:0] model_out(input logic wa, input logic wb);
        logic busy, we;
        busy = (m_owner != 0);
        we   = (m_owner == 1) ? wa : (m_owner == 2) ? wb : 1'b0;
        return {m_sel, busy, we, m_owner == 1, m_owner == 2,
                m_owner == 1 && m_left == 1, m_owner == 2 && m_left == 1, busy};
    endfunction

    // Inputs are changed 1 time unit after a rising edge; outputs sampled 2 units after.
    task automatic tick();
        model_edge(ReqA, ReqB);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        ReqA = 0; ReqB = 0; WeA = 0; WeB = 0;
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        ReqA = 1; ReqB = 1; WeA = 1; WeB = 1;
        model_reset();
        repeat (2) @(posedge Clk);
        #2;
        tests++;
        if (obs !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 8'h00);
        end
        #1;
        Reset_n = 1'b1;
        tick();
        #1;
        tests++;
        if (GntA !== 1'b1 || GntB !== 1'b0 || Sel !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_grant: got GntA=%b GntB=%b Sel=%b expected 1 0 0",
                     GntA, GntB, Sel);
        end
    endtask

    task automatic test_single_a();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'b0101_0001;
        exp_seq[1] = 8'b0101_0101;
        exp_seq[2] = 8'b0000_0000;
        do_reset();
        ReqA = 1;
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) ReqA = 0;  // dropped on the edge after Done
            #1;
            tests++;
            if (obs !== exp_seq[c]) begin
                fails++;
                $display("FAIL single_a_cycle%0d: got %b expected %b", c + 1, obs, exp_seq[c]);
            end
            tick();
        end
    endtask

    task automatic test_single_b(input logic web);
        logic [7:0] exp_seq [3];
        exp_seq[0] = {3'b11, web, 5'b0_1001};
        exp_seq[1] = {3'b11, web, 5'b0_1011};
        exp_seq[2] = 8'b1000_0000;  // Sel holds 1 in idle
        exp_seq[0] = {1'b1, 1'b1, web, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_seq[1] = {1'b1, 1'b1, web, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        ReqB = 1; WeB = web; WeA = 1;
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) ReqB = 0;
            #1;
            tests++;
            if (obs !== exp_seq[c]) begin
                fails++;
                $display("FAIL single_b_we%0b_cycle%0d: got %b expected %b",
                         web, c + 1, obs, exp_seq[c]);
            end
            tick();
        end
        WeA = 0; WeB = 0;
    endtask

    task automatic test_contention();
        int   bad_seq = 0;
        int   bad_excl = 0;
        int   bad_sel = 0;
        logic exp_a, exp_b, prev_sel;
        do_reset();
        ReqA = 1; ReqB = 1;
        prev_sel = Sel;
        for (int k = 0; k < 15; k++) begin
            tick();
            #1;
            exp_a = (k % 3 < 2) && ((k / 3) % 2 == 0);
            exp_b = (k % 3 < 2) && ((k / 3) % 2 == 1);
            if (GntA !== exp_a || GntB !== exp_b) bad_seq++;
            if (GntA && GntB) bad_excl++;
            if (Sel !== prev_sel && k % 3 != 0) bad_sel++;
            prev_sel = Sel;
        end
        tests++;
        if (bad_seq != 0) begin
            fails++;
            $display("FAIL contention_order: %0d bad cycles, expected 0", bad_seq);
        end
        tests++;
        if (bad_excl != 0 || bad_sel != 0) begin
            fails++;
            $display("FAIL contention_excl_sel: %0d overlap, %0d stray Sel changes, expected 0",
                     bad_excl, bad_sel);
        end
        ReqA = 0; ReqB = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ReqB = 1;
        tick();
        #1;
        tests++;
        if (GntB !== 1'b1 || DoneB !== 1'b0) begin
            fails++;
            $display("FAIL mid_busy_b: got GntB=%b DoneB=%b expected 1 0", GntB, DoneB);
        end
        Reset_n = 1'b0;
        #1;
        tests++;
        if (obs !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset_drop: got %b expected %b", obs, 8'h00);
        end
        ReqA = 1; ReqB = 1;
        model_reset();
        @(posedge Clk);
        #1;
        tests++;
        if (DoneB !== 1'b0 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_no_done: got DoneB=%b Busy=%b expected 0 0", DoneB, Busy);
        end
        Reset_n = 1'b1;
        tick();
        #1;
        tests++;
        if (GntA !== 1'b1 || GntB !== 1'b0) begin
            fails++;
            $display("FAIL mid_after_a_wins: got GntA=%b GntB=%b expected 1 0", GntA, GntB);
        end
        ReqA = 0; ReqB = 0;
    endtask

    task automatic test_random();
        logic [7:0] exp;
        int         bad = 0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            ReqA = 1'($urandom_range(0, 1));
            ReqB = 1'($urandom_range(0, 1));
            WeA  = 1'($urandom_range(0, 1));
            WeB  = 1'($urandom_range(0, 1));
            #1;
            exp = model_out(WeA, WeB);
            if (obs !== exp) begin
                bad++;
                if (bad <= 5) $display("FAIL random_cycle%0d: got %b expected %b", k, obs, exp);
            end
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL random_total: %0d bad cycles, expected 0", bad);
        end
        ReqA = 0; ReqB = 0; WeA = 0; WeB = 0;
    endtask

    task automatic test_latency1();
        logic [7:0] exp_seq [3];
        exp_seq[0] = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_seq[1] = 8'h00;
        exp_seq[2] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        Reset1_n = 1'b0;
        ReqA1 = 0; ReqB1 = 0; WeA1 = 1; WeB1 = 0;
        @(posedge Clk);
        #1;
        Reset1_n = 1'b1;
        ReqA1 = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk);
            #1;
            ReqA1 = 0;
            ReqB1 = (c == 1);
            #1;
            tests++;
            if (obs1 !== exp_seq[c]) begin
                fails++;
                $display("FAIL lat1_cycle%0d: got %b expected %b", c + 1, obs1, exp_seq[c]);
            end
        end
        ReqB1 = 0;
    endtask

    initial begin
        Reset1_n = 1'b0;
        ReqA1 = 0; ReqB1 = 0; WeA1 = 0; WeB1 = 0;
        test_reset();
        test_single_a();
        test_single_b(1'b1);
        test_single_b(1'b0);
        test_contention();
        test_reset_mid();
        test_random();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared single-port memory.
- Two requesters share the port: A is instruction fetch, B is data load/store.
- Drives the select of the shared 2:1 32-bit address/write-data muxes (Sel=0 passes A, Sel=1 passes B), plus memory enable and write enable.
- Counts a fixed access latency and returns a one-cycle done pulse to the owner.

Parameters:
- LATENCY, 2: memory access cycles per transaction; legal range 1..15.
- CNT_W, 4: width of the latency counter; must hold LATENCY-1.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- ReqA  input  1  requester A wants the port; held until DoneA.
- WeA  input  1  A write enable, sampled while A owns the port.
- ReqB  input  1  requester B wants the port; held until DoneB.
- WeB  input  1  B write enable, sampled while B owns the port.
- Sel  output  1  shared mux select; 0 = A path, 1 = B path.
- MemEn  output  1  memory enable; high for the whole transaction.
- MemWe  output  1  memory write enable; the owner's We, gated by MemEn.
- GntA  output  1  A owns the port (level).
- GntB  output  1  B owns the port (level).
- DoneA  output  1  one-cycle pulse on the final cycle of an A access.
- DoneB  output  1  one-cycle pulse on the final cycle of a B access.
- Busy  output  1  high in either BUSY state.

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is asynchronous and active-low.
- Reset while Reset_n=0, including mid-transaction:
  - state=IDLE, Cnt=0, LastB=1 (A gets priority on first contention).
  - Sel=0 and all other outputs 0.
  - An interrupted transaction is abandoned, with no Done pulse.
- States: IDLE, BUSY_A, BUSY_B. State, Cnt, LastB and Sel are registered.
- IDLE transitions, evaluated at the rising edge:
  - ReqA only -> BUSY_A.
  - ReqB only -> BUSY_B.
  - Both -> BUSY_A if LastB=1, else BUSY_B.
  - Neither -> stay in IDLE.
- Entering BUSY_x: Cnt<=0, Sel<=(x==B), LastB<=(x==B).
- Sel changes only on the IDLE->BUSY edge and holds its value in IDLE (glitch-free mux control).
- In BUSY_x:
  - Gntx=1, MemEn=1, Busy=1.
  - MemWe = Wex, combinational from the owner's We only.
  - Cnt increments each cycle.
- Completion: Donex is asserted combinationally when Cnt==LATENCY-1; the next edge returns to IDLE.
- LATENCY=1: Gntx and Donex occur in the same single cycle.
- A mandatory single IDLE bubble follows every transaction. The requester drops Req on the edge after Done, so it is not re-sampled.
- Requests and We changes during BUSY are ignored except the owner's We feeding MemWe.
- A requester that keeps Req high after Done gets a new transaction. Under contention the other requester wins because of LastB.
- Throughput: one transaction per LATENCY+1 cycles.
- Mutual exclusion: GntA & GntB is never 1, and DoneA & DoneB is never 1.

Test Plan:
- Reset: hold Reset_n=0 with ReqA=ReqB=1 -> all outputs 0, Sel=0. Release -> first edge enters BUSY_A, GntA=1.
- Single A read, LATENCY=2: ReqA=1 at edge 0.
  - -> Cycle 1: GntA=1, MemEn=1, Sel=0, DoneA=0.
  - -> Cycle 2: DoneA=1.
  - -> Cycle 3: IDLE, all 0.
- Single B write: ReqB=1, WeB=1, WeA=1.
  - -> Sel=1, MemWe=1 for 2 cycles, DoneB on the 2nd.
  - With WeB=0 -> MemWe stays 0 despite WeA=1.
- Contention: ReqA, ReqB held high continuously.
  - -> Grants alternate A,B,A,B with period 3 cycles, starting with A.
  - -> Sel toggles only on BUSY entry; never both grants high.
- Reset mid-op: assert Reset_n=0 asynchronously during cycle 1 of BUSY_B.
  - -> Outputs drop immediately, with no DoneB.
  - After release, ReqA and ReqB both high -> A wins.
- LATENCY=1 build: ReqA pulse -> GntA and DoneA high in the same single cycle, then IDLE.
